program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised program counter that generates the serial-memory fetch address, stepping once per byte-boundary strobe from the serial clock. It adds what the earlier counter lacked: fully synchronous single-clock operation, absolute jump/load, call/return via a small return-address stack, and a configurable wrap window. It sits between the serial clock generator (strobe source) and the memory address port.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of memAddr and loadAddr
- LAST_ADDR, 2**ADDR_WIDTH-1, highest address before wrap
- WRAP_ADDR, 93, address taken after LAST_ADDR (program start after header)
- STACK_DEPTH, 4, return-stack entries (≥1)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- sclk8PosEdge  in  1  one-clk-wide byte-boundary strobe; qualifies every action
- pcEn  in  1  increment enable
- loadEn  in  1  absolute jump to loadAddr
- callEn  in  1  push return address, jump to loadAddr
- retEn  in  1  pop return address into memAddr
- loadAddr  in  ADDR_WIDTH  jump/call target
- memAddr  out  ADDR_WIDTH  current fetch address
- stackEmpty  out  1  no entries on stack
- stackFull  out  1  STACK_DEPTH entries on stack
- stackErr  out  1  sticky: call on full or return on empty

## Operation
- Action evaluated only in cycles with sclk8PosEdge=1; otherwise all state holds.
- Priority in a strobe cycle: loadEn > callEn > retEn > pcEn > hold.
- next(a) = WRAP_ADDR if a == LAST_ADDR, else a+1 (ADDR_WIDTH modulo arithmetic, no carry out).
- Increment: memAddr ← next(memAddr).
- Load: memAddr ← loadAddr; stack untouched.
- Call, not full: push next(memAddr); memAddr ← loadAddr. Call when full: no push, memAddr unchanged, stackErr ← 1.
- Return, not empty: memAddr ← top; pop. Return when empty: memAddr unchanged, stackErr ← 1.
- Lower-priority requests in the same strobe cycle are dropped, not queued.
- stackErr clears only on reset.
- loadAddr above LAST_ADDR is accepted as-is; the next increment from it proceeds a+1 (wrap only on exact match).

## Timing
- Reset (reset=0, asynchronous): memAddr=0, stack pointer=0, stackEmpty=1, stackFull=0, stackErr=0; entry contents don't-care.
- Release of reset synchronised by the integrator; block responds from the first rising edge with reset=1.
- Latency: strobe sampled at edge N, memAddr and flags valid after edge N (one clk).
- stackEmpty/stackFull are registered-state decodes, updated same edge as the push/pop.
- Back-to-back strobes on consecutive clks each act independently.
- Reset asserted mid-operation overrides any in-progress action immediately.

## Structure
- Package pc_pkg: default ADDR_WIDTH, default WRAP_ADDR, operation enum (PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET) produced by the priority decoder.
- Sub-module return_stack: LIFO of STACK_DEPTH × ADDR_WIDTH with push, pop, top, empty, full; same clk/reset.
- Top level: priority decode, next() function, memAddr register, stackErr register.

## Test plan
(ADDR_WIDTH=8, LAST_ADDR=255, WRAP_ADDR=93, STACK_DEPTH=2 unless stated)
- Reset, pcEn=1, 5 strobes spaced 8 clks -> memAddr 0,1,2,3,4,5; no change on non-strobe clks; pcEn=0 strobes hold.
- loadEn with loadAddr=254, then 3 increment strobes -> 254, 255, 93, 94.
- callEn loadAddr=40 at memAddr=10, call loadAddr=60, ret, ret -> 40, 60, 41, 11; stackFull=1 after second call, stackEmpty=1 at end; stackErr=0.
- Third call while full at memAddr=60 -> memAddr stays 60, stackErr=1 and remains 1; retEn on empty stack likewise holds memAddr, stackErr=1.
- Same strobe with loadEn=1, callEn=1, retEn=1, pcEn=1, loadAddr=7 -> memAddr=7, stack depth unchanged; callEn+retEn+pcEn -> call performed.
- Assert reset asynchronously between clk edges with stack depth 2, memAddr=60 -> memAddr=0, stackEmpty=1, stackErr=0 before next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared defaults and the operation encoding used by the program sequencer.
package pc_pkg;

  localparam int unsigned PC_ADDR_WIDTH = 16;
  localparam int unsigned PC_WRAP_ADDR  = 93;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Fixed priority: load beats call beats return beats increment.
  function automatic pc_op_e decodeOp(input logic load, input logic call,
                                      input logic ret, input logic inc);
    if (load)      return PC_LOAD;
    else if (call) return PC_CALL;
    else if (ret)  return PC_RET;
    else if (inc)  return PC_INC;
    else           return PC_HOLD;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Small LIFO holding return addresses for call/return.
module return_stack #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] pushData,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PW-1:0]         sp;
  logic [IW-1:0]         topIdx;
  logic [ADDR_WIDTH-1:0] entries [STACK_DEPTH];

  assign empty = (sp == '0);
  assign full  = (sp == PW'(STACK_DEPTH));

  // Clamp the index when empty so the read never leaves the array.
  always_comb begin
    topIdx = '0;
    if (!empty) topIdx = IW'(sp - 1'b1);
  end

  assign top = entries[topIdx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) entries[sp[IW-1:0]] <= pushData;
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter for serial-memory fetch: increment, jump, call/return
// with a return stack, and a configurable wrap window.
module program_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = PC_ADDR_WIDTH,
  parameter int unsigned LAST_ADDR   = 2**ADDR_WIDTH - 1,
  parameter int unsigned WRAP_ADDR   = PC_WRAP_ADDR,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk8PosEdge,
  input  logic                  pcEn,
  input  logic                  loadEn,
  input  logic                  callEn,
  input  logic                  retEn,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  stackEmpty,
  output logic                  stackFull,
  output logic                  stackErr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] WRAP = ADDR_WIDTH'(WRAP_ADDR);

  pc_op_e                op;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] stackTop;

  // Wrap only on an exact match so loads above LAST keep counting upward.
  function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] a);
    if (a == LAST) return WRAP;
    else           return a + 1'b1;
  endfunction

  assign op   = decodeOp(loadEn, callEn, retEn, pcEn);
  assign push = sclk8PosEdge && (op == PC_CALL) && !stackFull;
  assign pop  = sclk8PosEdge && (op == PC_RET) && !stackEmpty;

  return_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .pushData(nextAddr(memAddr)),
    .top     (stackTop),
    .empty   (stackEmpty),
    .full    (stackFull)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memAddr  <= '0;
      stackErr <= 1'b0;
    end else if (sclk8PosEdge) begin
      unique case (op)
        PC_INC:  memAddr <= nextAddr(memAddr);
        PC_LOAD: memAddr <= loadAddr;
        PC_CALL: begin
          if (!stackFull) memAddr  <= loadAddr;
          else            stackErr <= 1'b1;
        end
        PC_RET: begin
          if (!stackEmpty) memAddr  <= stackTop;
          else             stackErr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer with an 8-bit address, depth-2 stack.
module tb_program_sequencer;

  typedef struct {
    string      tag;
    logic [7:0] addr;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk8PosEdge = 1'b0;
  logic       pcEn = 1'b0;
  logic       loadEn = 1'b0;
  logic       callEn = 1'b0;
  logic       retEn = 1'b0;
  logic [7:0] loadAddr = '0;
  logic [7:0] memAddr;
  logic       stackEmpty;
  logic       stackFull;
  logic       stackErr;

  exp_t sbQ[$];
  logic issued = 1'b0;
  logic issuedD = 1'b0;
  int   vecCount = 0;
  int   missCount = 0;

  program_sequencer #(
    .ADDR_WIDTH (8),
    .LAST_ADDR  (255),
    .WRAP_ADDR  (93),
    .STACK_DEPTH(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk8PosEdge(sclk8PosEdge),
    .pcEn        (pcEn),
    .loadEn      (loadEn),
    .callEn      (callEn),
    .retEn       (retEn),
    .loadAddr    (loadAddr),
    .memAddr     (memAddr),
    .stackEmpty  (stackEmpty),
    .stackFull   (stackFull),
    .stackErr    (stackErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) issuedD <= issued;

  task automatic compareExp(input exp_t e);
    vecCount++;
    if (memAddr !== e.addr || stackEmpty !== e.empty ||
        stackFull !== e.full || stackErr !== e.err) begin
      missCount++;
      $display("[TB] FAIL %s: got addr=%0d empty=%0b full=%0b err=%0b, want addr=%0d empty=%0b full=%0b err=%0b",
               e.tag, memAddr, stackEmpty, stackFull, stackErr,
               e.addr, e.empty, e.full, e.err);
    end
  endtask

  // Monitor: one clock after each issued vector, pop and compare.
  always @(negedge clk) begin
    if (issuedD) begin
      if (sbQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL scoreboard: got output with empty queue, want a queued expectation");
      end else begin
        compareExp(sbQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic stb, input logic inc, input logic ld,
                               input logic cl, input logic rt, input logic [7:0] addr,
                               input string tag, input logic [7:0] eAddr,
                               input logic eEmpty, input logic eFull, input logic eErr);
    exp_t e;
    @(negedge clk);
    sclk8PosEdge = stb;
    pcEn = inc;
    loadEn = ld;
    callEn = cl;
    retEn = rt;
    loadAddr = addr;
    e.tag = tag;
    e.addr = eAddr;
    e.empty = eEmpty;
    e.full = eFull;
    e.err = eErr;
    sbQ.push_back(e);
    issued = 1'b1;
    @(posedge clk);
    #1;
    sclk8PosEdge = 1'b0;
    issued = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] eAddr,
                             input logic eEmpty, input logic eFull, input logic eErr);
    exp_t e;
    e.tag = tag;
    e.addr = eAddr;
    e.empty = eEmpty;
    e.full = eFull;
    e.err = eErr;
    compareExp(e);
  endtask

  initial begin
    int waitCycles;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 8'd0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;

    // Increments on strobes spaced 8 clocks, holds between them.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 8'd0, $sformatf("inc_%0d", i), 8'(i), 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 8'd0, $sformatf("nostrobe_%0d", i), 8'(i), 1, 0, 0);
      idle(6);
    end
    applyStimulus(1, 0, 0, 0, 0, 8'd0, "hold_pcen0", 8'd5, 1, 0, 0);

    // Wrap window.
    applyStimulus(1, 0, 1, 0, 0, 8'd254, "load_254", 8'd254, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 8'd0, "inc_255", 8'd255, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 8'd0, "wrap_93", 8'd93, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 8'd0, "inc_94", 8'd94, 1, 0, 0);

    // Nested call/return.
    applyStimulus(1, 0, 1, 0, 0, 8'd10, "load_10", 8'd10, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 8'd40, "call_40", 8'd40, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 8'd60, "call_60", 8'd60, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 8'd0, "ret_41", 8'd41, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 8'd0, "ret_11", 8'd11, 1, 0, 0);

    // Overflow and underflow set the sticky error.
    applyStimulus(1, 0, 0, 1, 0, 8'd40, "call2_40", 8'd40, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 8'd60, "call2_60", 8'd60, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0, 8'd80, "call_full", 8'd60, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 8'd0, "err_sticky", 8'd61, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 8'd0, "ret2_41", 8'd41, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 8'd0, "ret2_12", 8'd12, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 8'd0, "ret_empty", 8'd12, 1, 0, 1);

    // Priority among simultaneous requests.
    applyStimulus(1, 1, 1, 1, 1, 8'd7, "prio_load", 8'd7, 1, 0, 1);
    applyStimulus(1, 1, 0, 1, 1, 8'd20, "prio_call", 8'd20, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1, 8'd0, "prio_ret", 8'd8, 1, 0, 1);

    // Asynchronous reset between edges with a full stack.
    applyStimulus(1, 0, 1, 0, 0, 8'd10, "load3_10", 8'd10, 1, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 8'd40, "call3_40", 8'd40, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 8'd60, "call3_60", 8'd60, 0, 1, 1);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 8'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 8'd0, "post_reset_inc", 8'd1, 1, 0, 0);

    waitCycles = 0;
    while (sbQ.size() != 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (sbQ.size() != 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", sbQ.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
